instruction_decode_stage: RTL and testbench



---
 rtl/instruction_decode_stage_pkg.sv | 31 +++
 rtl/instruction_decode_stage_field_unpack.sv | 30 +++
 rtl/instruction_decode_stage.sv | 149 ++++++++++++++
 tb/tb_instruction_decode_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: default field widths,
// instruction-width derivation and the decoded-entry layout.
package instruction_decode_stage_pkg;

    localparam int unsigned DEF_GROUP_W    = 3;
    localparam int unsigned DEF_CMD_W      = 3;
    localparam int unsigned DEF_ARG_W      = 8;
    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_NUM_GROUPS = 6;

    // Total instruction width: group, command, two (type bit + argument) pairs, address.
    function automatic int unsigned calc_instr_w(input int unsigned group_w,
                                                 input int unsigned cmd_w,
                                                 input int unsigned arg_w,
                                                 input int unsigned addr_w);
        return group_w + cmd_w + 2 * (1 + arg_w) + addr_w;
    endfunction

    // Decoded entry at default widths; the illegal flag sits above the fields.
    typedef struct packed {
        logic                  illegal;
        logic [DEF_GROUP_W-1:0] command_group;
        logic [DEF_CMD_W-1:0]   command;
        logic                  arg_type_1;
        logic [DEF_ARG_W-1:0]   arg_1;
        logic                  arg_type_2;
        logic [DEF_ARG_W-1:0]   arg_2;
        logic [DEF_ADDR_W-1:0]  address;
    } decoded_t;

endpackage

// File: rtl/instruction_decode_stage_field_unpack.sv
// Combinational split of a raw instruction word into its fields, plus the
// illegal-group flag (group index outside 0..NUM_GROUPS-1).
module instruction_field_unpack
    import instruction_decode_stage_pkg::*;
#(
    parameter  int unsigned GROUP_W    = DEF_GROUP_W,
    parameter  int unsigned CMD_W      = DEF_CMD_W,
    parameter  int unsigned ARG_W      = DEF_ARG_W,
    parameter  int unsigned ADDR_W     = DEF_ADDR_W,
    parameter  int unsigned NUM_GROUPS = DEF_NUM_GROUPS,
    localparam int unsigned INSTR_W    = calc_instr_w(GROUP_W, CMD_W, ARG_W, ADDR_W)
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [GROUP_W-1:0] group_o,
    output logic [CMD_W-1:0]   command_o,
    output logic               arg_type_1_o,
    output logic [ARG_W-1:0]   arg_1_o,
    output logic               arg_type_2_o,
    output logic [ARG_W-1:0]   arg_2_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               illegal_o
);

    // Field order MSB to LSB: group, command, arg_type_1, arg_1, arg_type_2, arg_2, address.
    always_comb begin
        {group_o, command_o, arg_type_1_o, arg_1_o, arg_type_2_o, arg_2_o, address_o} = instr_i;
        illegal_o = (32'(group_o) >= NUM_GROUPS);
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: decodes each accepted word and buffers it in a
// 2-entry FIFO with valid/ready handshakes on both sides.
// Optional build macro DECODE_STAGE_STATS_EN adds saturating pop counters
// (decoded_count, illegal_count) that only rst clears.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
#(
    parameter  int unsigned GROUP_W    = DEF_GROUP_W,
    parameter  int unsigned CMD_W      = DEF_CMD_W,
    parameter  int unsigned ARG_W      = DEF_ARG_W,
    parameter  int unsigned ADDR_W     = DEF_ADDR_W,
    parameter  int unsigned NUM_GROUPS = DEF_NUM_GROUPS,
    localparam int unsigned INSTR_W    = calc_instr_w(GROUP_W, CMD_W, ARG_W, ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GROUP_W-1:0] command_group,
    output logic [CMD_W-1:0]   command,
    output logic               arg_type_1,
    output logic [ARG_W-1:0]   arg_1,
    output logic               arg_type_2,
    output logic [ARG_W-1:0]   arg_2,
    output logic [ADDR_W-1:0]  address,
    output logic               illegal
`ifdef DECODE_STAGE_STATS_EN
    ,
    output logic [31:0]        decoded_count,
    output logic [15:0]        illegal_count
`endif
);

    localparam int unsigned ENTRY_W = INSTR_W + 1;

    logic [GROUP_W-1:0] dec_group;
    logic [CMD_W-1:0]   dec_command;
    logic               dec_arg_type_1;
    logic [ARG_W-1:0]   dec_arg_1;
    logic               dec_arg_type_2;
    logic [ARG_W-1:0]   dec_arg_2;
    logic [ADDR_W-1:0]  dec_address;
    logic               dec_illegal;

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               push, pop;

    instruction_field_unpack #(
        .GROUP_W    (GROUP_W),
        .CMD_W      (CMD_W),
        .ARG_W      (ARG_W),
        .ADDR_W     (ADDR_W),
        .NUM_GROUPS (NUM_GROUPS)
    ) u_unpack (
        .instr_i      (instruction),
        .group_o      (dec_group),
        .command_o    (dec_command),
        .arg_type_1_o (dec_arg_type_1),
        .arg_1_o      (dec_arg_1),
        .arg_type_2_o (dec_arg_type_2),
        .arg_2_o      (dec_arg_2),
        .address_o    (dec_address),
        .illegal_o    (dec_illegal)
    );

    assign push_entry = {dec_illegal, dec_group, dec_command, dec_arg_type_1, dec_arg_1,
                         dec_arg_type_2, dec_arg_2, dec_address};

    // Handshake status comes only from the registered count.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head entry drives the outputs, forced to zero while nothing is buffered.
    always_comb begin
        head_entry = out_valid ? mem_q[rd_ptr_q] : '0;
        {illegal, command_group, command, arg_type_1, arg_1, arg_type_2, arg_2, address} = head_entry;
    end

`ifdef DECODE_STAGE_STATS_EN
    logic [31:0] decoded_count_q;
    logic [15:0] illegal_count_q;

    // Saturating pop statistics; a flush suppresses the pop so nothing is counted then.
    always_ff @(posedge clk) begin
        if (rst) begin
            decoded_count_q <= '0;
            illegal_count_q <= '0;
        end else if (pop && !flush) begin
            if (decoded_count_q != '1) decoded_count_q <= decoded_count_q + 32'd1;
            if (illegal && illegal_count_q != '1) illegal_count_q <= illegal_count_q + 16'd1;
        end
    end

    assign decoded_count = decoded_count_q;
    assign illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage at default widths.
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  command_group;
    logic [2:0]  command;
    logic        arg_type_1;
    logic [7:0]  arg_1;
    logic        arg_type_2;
    logic [7:0]  arg_2;
    logic [7:0]  address;
    logic        illegal;
`ifdef DECODE_STAGE_STATS_EN
    logic [31:0] decoded_count;
    logic [15:0] illegal_count;
`endif

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    logic [31:0] out_word;
    assign out_word = {command_group, command, arg_type_1, arg_1, arg_type_2, arg_2, address};

    instruction_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .command_group (command_group),
        .command       (command),
        .arg_type_1    (arg_type_1),
        .arg_1         (arg_1),
        .arg_type_2    (arg_type_2),
        .arg_2         (arg_2),
        .address       (address),
        .illegal       (illegal)
`ifdef DECODE_STAGE_STATS_EN
        ,
        .decoded_count (decoded_count),
        .illegal_count (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] word, input logic ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".word"}, 64'(out_word), 64'(word));
        check({tag, ".illegal"}, 64'(illegal), 64'(ill));
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".ready"}, 64'(in_ready), 64'd1);
        check({tag, ".word"}, 64'(out_word), 64'd0);
        check({tag, ".illegal"}, 64'(illegal), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] stream_word(input int unsigned k);
        logic [2:0]  g;
        logic [28:0] rest;
        g    = 3'(k % 8);
        rest = 29'(k * 32'd7919 + 32'd13);
        return {g, rest};
    endfunction

    int unsigned exp_illegal;

    initial begin
        // Reset state
        do_reset();
        expect_empty("reset");

        // Single word, fields checked one by one
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h2A81_4010;
        tick();
        in_valid = 1'b0;
        check("single.valid", 64'(out_valid), 64'd1);
        check("single.group", 64'(command_group), 64'd1);
        check("single.cmd", 64'(command), 64'd2);
        check("single.at1", 64'(arg_type_1), 64'd1);
        check("single.arg1", 64'(arg_1), 64'h40);
        check("single.at2", 64'(arg_type_2), 64'd1);
        check("single.arg2", 64'(arg_2), 64'h40);
        check("single.addr", 64'(address), 64'h10);
        check("single.illegal", 64'(illegal), 64'd0);
        tick();
        expect_empty("single.drained");

        // Backpressure: three back-to-back words with out_ready low
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h1111_1111;
        tick();
        check("bp.ready1", 64'(in_ready), 64'd1);
        expect_head("bp.head1", 32'h1111_1111, 1'b0);
        instruction = 32'h4222_2222;
        tick();
        check("bp.ready2", 64'(in_ready), 64'd0);
        expect_head("bp.hold", 32'h1111_1111, 1'b0);
        instruction = 32'h8333_3333;
        tick();
        check("bp.ready3", 64'(in_ready), 64'd0);
        expect_head("bp.stable", 32'h1111_1111, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_head("bp.out2", 32'h4222_2222, 1'b0);
        check("bp.ready4", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        expect_head("bp.out3", 32'h8333_3333, 1'b0);
        tick();
        expect_empty("bp.drained");

        // Illegal-group boundary: 7 and 6 illegal, 5 legal
        in_valid    = 1'b1;
        instruction = 32'hE000_0001;
        tick();
        expect_head("grp7", 32'hE000_0001, 1'b1);
        instruction = 32'hA000_0002;
        tick();
        expect_head("grp5", 32'hA000_0002, 1'b0);
        instruction = 32'hC000_0003;
        tick();
        in_valid = 1'b0;
        expect_head("grp6", 32'hC000_0003, 1'b1);
        tick();
        expect_empty("grp.drained");

        // Flush while full with a concurrent push
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0000_00AA;
        tick();
        instruction = 32'h0000_00BB;
        tick();
        check("flush.full", 64'(in_ready), 64'd0);
        flush       = 1'b1;
        instruction = 32'h0000_00CC;
        out_ready   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_empty("flush.next");
        tick();
        expect_empty("flush.absent");

        // Streaming 100 words at one per cycle, statistics from a clean reset
        do_reset();
        exp_illegal = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        for (int unsigned k = 0; k < 100; k++) begin
            instruction = stream_word(k);
            if ((k % 8) >= 6) exp_illegal++;
            tick();
            expect_head("stream", stream_word(k), ((k % 8) >= 6));
            check("stream.ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        expect_empty("stream.drained");
`ifdef DECODE_STAGE_STATS_EN
        check("stats.decoded", 64'(decoded_count), 64'd100);
        check("stats.illegal", 64'(illegal_count), 64'(exp_illegal));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stats.flush_keeps", 64'(decoded_count), 64'd100);
`endif

        // Reset while holding two entries, handshakes active in the same cycle
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0101_0101;
        tick();
        instruction = 32'h0202_0202;
        tick();
        check("rstmid.full", 64'(in_ready), 64'd0);
        rst         = 1'b1;
        out_ready   = 1'b1;
        instruction = 32'h0303_0303;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        expect_empty("rstmid.next");
        tick();
        expect_empty("rstmid.after");
`ifdef DECODE_STAGE_STATS_EN
        check("stats.rst_clears", 64'(decoded_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
